// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 Set-2 scan-code decoder: prefix/modifier codes,
// FSM state encoding and the private ASCII codes used for the arrow keys.
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;

  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;

  // Bytes remaining in the Pause sequence after its leading E1
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  // Keyboard housekeeping bytes (BAT, ACK, echo, errors) that carry no key
  function automatic logic is_filler(input logic [7:0] code);
    return (code == SC_BAT) || (code == SC_ACK) || (code == SC_ECHO) ||
           (code == 8'h00) || (code == 8'hFF);
  endfunction

  // Keys that only change modifier state and never produce a character
  function automatic logic is_modifier(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
           (code == SC_CTRL) || (code == SC_CAPS);
  endfunction

endpackage

// File: rtl/kbd_ascii_lut.sv
// Combinational Set-2 scan code to ASCII table. Letters are always returned
// lower case; the caller applies caps/shift/ctrl. 8'h00 means unmapped.
module kbd_ascii_lut
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  // Table lookup; extended codes use a separate, much smaller map
  always_comb begin
    ascii = 8'h00;
    if (ext) begin
      case (code)
        8'h75:   ascii = KEY_UP;
        8'h72:   ascii = KEY_DOWN;
        8'h6B:   ascii = KEY_LEFT;
        8'h74:   ascii = KEY_RIGHT;
        8'h4A:   ascii = "/";
        8'h5A:   ascii = 8'h0D;
        default: ascii = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1C: ascii = "a";  8'h32: ascii = "b";  8'h21: ascii = "c";
        8'h23: ascii = "d";  8'h24: ascii = "e";  8'h2B: ascii = "f";
        8'h34: ascii = "g";  8'h33: ascii = "h";  8'h43: ascii = "i";
        8'h3B: ascii = "j";  8'h42: ascii = "k";  8'h4B: ascii = "l";
        8'h3A: ascii = "m";  8'h31: ascii = "n";  8'h44: ascii = "o";
        8'h4D: ascii = "p";  8'h15: ascii = "q";  8'h2D: ascii = "r";
        8'h1B: ascii = "s";  8'h2C: ascii = "t";  8'h3C: ascii = "u";
        8'h2A: ascii = "v";  8'h1D: ascii = "w";  8'h22: ascii = "x";
        8'h35: ascii = "y";  8'h1A: ascii = "z";
        8'h16: ascii = shift ? "!" : "1";
        8'h1E: ascii = shift ? "@" : "2";
        8'h26: ascii = shift ? "#" : "3";
        8'h25: ascii = shift ? "$" : "4";
        8'h2E: ascii = shift ? "%" : "5";
        8'h36: ascii = shift ? "^" : "6";
        8'h3D: ascii = shift ? "&" : "7";
        8'h3E: ascii = shift ? "*" : "8";
        8'h46: ascii = shift ? "(" : "9";
        8'h45: ascii = shift ? ")" : "0";
        8'h4E: ascii = shift ? "_" : "-";
        8'h55: ascii = shift ? "+" : "=";
        8'h54: ascii = shift ? "{" : "[";
        8'h5B: ascii = shift ? "}" : "]";
        8'h5D: ascii = shift ? "|" : "\\";
        8'h4C: ascii = shift ? ":" : ";";
        8'h52: ascii = shift ? "\"" : "'";
        8'h0E: ascii = shift ? "~" : 8'h60;
        8'h41: ascii = shift ? "<" : ",";
        8'h49: ascii = shift ? ">" : ".";
        8'h4A: ascii = shift ? "?" : "/";
        8'h29: ascii = " ";
        8'h5A: ascii = 8'h0D;
        8'h66: ascii = 8'h08;
        8'h0D: ascii = 8'h09;
        8'h76: ascii = 8'h1B;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: synchronises the receiver's byte-ready level,
// walks make/break/extended/pause sequences, tracks modifiers and queues ASCII
// characters in a small FIFO drained through valid/ready.
module kbd_scancode_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_rda,
  input  logic [7:0] kbd_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_ascii,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       caps_on
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] rda_sync;
  logic                   rda_prev;
  logic                   rda_rise;
  logic [7:0]             code_q;
  logic                   code_vld;

  state_t     state, state_next;
  logic [2:0] skip_cnt, skip_next;
  logic       make_ev, brk_ev, ev_ext;

  logic       lshift, rshift, lctrl, rctrl;
  logic       shift, ctrl, letter;
  logic [7:0] lut_ascii, char;
  logic       wr_req;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fill;
  logic        full, empty, pop, push, drop;

  // Synchronise the byte-ready level into clk and keep its previous value for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rda_sync <= '0;
      rda_prev <= 1'b0;
    end else begin
      rda_sync <= {rda_sync[SYNC_STAGES-2:0], kbd_rda};
      rda_prev <= rda_sync[SYNC_STAGES-1];
    end
  end

  assign rda_rise = rda_sync[SYNC_STAGES-1] & ~rda_prev;

  // Capture the scan code on the synchronised rising edge; kbd_data is stable by then
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q   <= 8'h00;
      code_vld <= 1'b0;
    end else begin
      code_vld <= rda_rise;
      if (rda_rise) code_q <= kbd_data;
    end
  end

  // Sequence FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // Next state plus make/break events for the byte presented this cycle
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    make_ev    = 1'b0;
    brk_ev     = 1'b0;
    ev_ext     = 1'b0;
    if (code_vld) begin
      case (state)
        ST_IDLE: begin
          if (code_q == SC_EXT) begin
            state_next = ST_EXT;
          end else if (code_q == SC_BRK) begin
            state_next = ST_BRK;
          end else if (code_q == SC_PAUSE) begin
            state_next = ST_SKIP;
            skip_next  = PAUSE_SKIP;
          end else if (!is_filler(code_q)) begin
            make_ev = 1'b1;
          end
        end
        ST_EXT: begin
          if (code_q == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else begin
            state_next = ST_IDLE;
            // E0 12 is the keyboard's fake shift around extended keys
            if (code_q != SC_LSHIFT) begin
              make_ev = 1'b1;
              ev_ext  = 1'b1;
            end
          end
        end
        ST_BRK: begin
          brk_ev     = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_ev     = 1'b1;
          ev_ext     = 1'b1;
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_cnt <= 3'd1) begin
            skip_next  = 3'd0;
            state_next = ST_IDLE;
          end else begin
            skip_next = skip_cnt - 3'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Modifier flags follow make/break; caps lock toggles on every make, repeats included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lshift  <= 1'b0;
      rshift  <= 1'b0;
      lctrl   <= 1'b0;
      rctrl   <= 1'b0;
      caps_on <= 1'b0;
    end else if (make_ev || brk_ev) begin
      if (code_q == SC_LSHIFT) lshift <= make_ev;
      if (code_q == SC_RSHIFT) rshift <= make_ev;
      if (code_q == SC_CTRL) begin
        if (ev_ext) rctrl <= make_ev;
        else        lctrl <= make_ev;
      end
      if (code_q == SC_CAPS && make_ev) caps_on <= ~caps_on;
    end
  end

  assign shift = lshift | rshift;
  assign ctrl  = lctrl | rctrl;

  kbd_ascii_lut u_lut (
    .code  (code_q),
    .ext   (ev_ext),
    .shift (shift),
    .ascii (lut_ascii)
  );

  // Apply caps/shift case flip and ctrl masking to letters only
  always_comb begin
    letter = (lut_ascii >= 8'h61) && (lut_ascii <= 8'h7A);
    char   = lut_ascii;
    if (letter && (caps_on ^ shift)) char = lut_ascii ^ 8'h20;
    if (letter && ctrl)              char = char & 8'h1F;
  end

  assign wr_req = make_ev && !is_modifier(code_q) && (lut_ascii != 8'h00);

  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == (AW+1)'(FIFO_DEPTH));
  assign empty     = (fill == '0);
  assign out_valid = !empty;
  assign out_ascii = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
  assign push      = wr_req && (!full || pop);
  assign drop      = wr_req && full && !pop;

  // FIFO storage, no reset needed since empty masks the head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= char;
  end

  // FIFO pointers and sticky overflow (a drop beats a clear in the same cycle)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Directed plus randomized bench for kbd_scancode_decoder with a key-level model.
module tb_kbd_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_rda = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid, overflow, caps_on;
  logic [7:0] out_ascii;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46, 8'h45};
  logic [7:0] arrow_sc [4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
  string dig_lo = "1234567890";
  string dig_hi = "!@#$%^&*()";

  bit m_lsh, m_rsh, m_ctl, m_caps;

  kbd_scancode_decoder #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .kbd_rda   (kbd_rda),
    .kbd_data  (kbd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ascii (out_ascii),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .caps_on   (caps_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One receiver byte: rda high 4 cycles then low 4 cycles; FIFO write done on return
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    kbd_data = b;
    kbd_rda  = 1'b1;
    repeat (4) @(negedge clk);
    kbd_rda = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Pop everything with out_ready=1 and compare against the expected queue
  task automatic drain(input string tag);
    int guard = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (out_valid && guard < 32) begin
      check({tag, "_char"}, out_ascii, (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00);
      $display("pop %s char=%02h", tag, out_ascii);
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic logic [7:0] model_letter(input int idx);
    logic [7:0] c;
    c = 8'h61 + 8'(idx);
    if (m_caps ^ (m_lsh | m_rsh)) c = c - 8'h20;
    if (m_ctl) c = c & 8'h1F;
    return c;
  endfunction

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ascii", out_ascii, 8'h00);
    check("rst_ovf",   overflow,  1'b0);
    check("rst_caps",  caps_on,   1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: make of 'a' with exact latency, then its break
    @(negedge clk);
    kbd_data = 8'h1C;
    kbd_rda  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_lat_early", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t1_lat", out_valid, 1'b1);
    check("t1_head", out_ascii, 8'h61);
    repeat (2) @(negedge clk);
    kbd_rda = 1'b0;
    repeat (4) @(negedge clk);
    send(8'hF0); send(8'h1C);
    exp_q.push_back(8'h61);
    drain("t1");

    // 2: shift, caps, caps+shift
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    check("t2_caps_on", caps_on, 1'b1);
    send(8'h59); send(8'h1C); send(8'hF0); send(8'h59);
    send(8'h58); send(8'hF0); send(8'h58);
    check("t2_caps_off", caps_on, 1'b0);
    exp_q.push_back(8'h41); exp_q.push_back(8'h41); exp_q.push_back(8'h61);
    drain("t2");

    // 3: ctrl-c, arrows, extended break, fake shift
    send(8'h14); send(8'h21); send(8'hF0); send(8'h21); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'h6B);
    send(8'h1C);
    exp_q.push_back(8'h03); exp_q.push_back(8'h80);
    exp_q.push_back(8'h82); exp_q.push_back(8'h61);
    drain("t3");

    // 4: pause sequence swallowed, ctrl not latched
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C); send(8'h21);
    exp_q.push_back(8'h61); exp_q.push_back(8'h63);
    drain("t4");

    // 5: overflow, clear, full+pop+write
    for (int i = 0; i < 9; i++) begin
      send(8'h1C);
      if (i == 7) check("t5_no_ovf_at_8", overflow, 1'b0);
    end
    check("t5_ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h61);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("t5_ovf_clr", overflow, 1'b0);
    @(negedge clk);
    kbd_data = 8'h21;
    kbd_rda  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h63);
    repeat (2) @(negedge clk);
    kbd_rda = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_pop_write_ovf", overflow, 1'b0);
    drain("t5");

    // 6: reset mid-sequence
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'hF0);
    check("t6_pre_caps", caps_on, 1'b1);
    check("t6_pre_valid", out_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_ascii", out_ascii, 8'h00);
    check("t6_rst_ovf",   overflow,  1'b0);
    check("t6_rst_caps",  caps_on,   1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    send(8'h1C);
    exp_q.push_back(8'h61);
    drain("t6");

    // Randomized key events against the key-level model
    m_lsh = 0; m_rsh = 0; m_ctl = 0; m_caps = 0;
    for (int b = 0; b < 6; b++) begin
      for (int e = 0; e < 8; e++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k <= 3) begin
          int idx;
          idx = $urandom_range(0, 25);
          send(letter_sc[idx]);
          exp_q.push_back(model_letter(idx));
        end else if (k == 4) begin
          int idx;
          idx = $urandom_range(0, 25);
          send(8'hF0); send(letter_sc[idx]);
        end else if (k == 5) begin
          int idx;
          idx = $urandom_range(0, 9);
          send(digit_sc[idx]);
          exp_q.push_back((m_lsh | m_rsh) ? dig_hi[idx] : dig_lo[idx]);
        end else if (k == 6) begin
          if ($urandom_range(0, 1) == 0) begin
            if (m_lsh) begin send(8'hF0); send(8'h12); end
            else       send(8'h12);
            m_lsh = !m_lsh;
          end else begin
            if (m_rsh) begin send(8'hF0); send(8'h59); end
            else       send(8'h59);
            m_rsh = !m_rsh;
          end
        end else if (k == 7) begin
          if (m_ctl) begin send(8'hF0); send(8'h14); end
          else       send(8'h14);
          m_ctl = !m_ctl;
        end else if (k == 8) begin
          send(8'h58); send(8'hF0); send(8'h58);
          m_caps = !m_caps;
        end else begin
          int a;
          a = $urandom_range(0, 3);
          send(8'hE0); send(arrow_sc[a]);
          exp_q.push_back(8'h80 + 8'(a));
        end
      end
      drain("rnd");
      check("rnd_caps", caps_on, m_caps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
